// File: rtl/xor_descrambler.sv
// XOR descrambler: 16-bit Fibonacci LFSR keystream (fully unrolled, N bits
// per word) XORed onto each accepted word. A single output register with
// pass-through ready gives one word per cycle at full throughput.
module xor_descrambler #(
  parameter int          N    = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_load,
  input  logic [15:0]  seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [15:0]  word_cnt
);

  localparam logic [0:0] S_UNSEEDED = 1'b0;
  localparam logic [0:0] S_RUN      = 1'b1;

  logic [0:0]   r_state;
  logic [15:0]  r_lfsr;
  logic         r_out_valid;
  logic [N-1:0] r_out_data;
  logic [15:0]  r_word_cnt;

  // w_st[k] is the LFSR state after k steps; keystream bit k is its LSB.
  logic [15:0]  w_st [0:N];
  logic [N-1:0] w_ks;
  logic         w_in_ready;
  logic         w_accept;
  logic [15:0]  w_seed_eff;

  assign w_st[0] = r_lfsr;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : gen_ks
      assign w_ks[k]    = w_st[k][0];
      assign w_st[k+1]  = {w_st[k][0] ^ w_st[k][2] ^ w_st[k][3] ^ w_st[k][5],
                           w_st[k][15:1]};
    end
  endgenerate

  // A zero seed would lock the LFSR at zero, so substitute the default.
  assign w_seed_eff = (seed == 16'h0000) ? SEED : seed;

  // seed_load blocks acceptance so a word never sees a half-updated keystream.
  assign w_in_ready = (r_state == S_RUN) & ~seed_load & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  // UNSEEDED -> RUN on the first seed load; only reset returns to UNSEEDED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_state <= S_UNSEEDED;
    else if (seed_load) r_state <= S_RUN;
  end

  // LFSR reload on seed_load, otherwise advance N steps per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_lfsr <= SEED;
    else if (seed_load) r_lfsr <= w_seed_eff;
    else if (w_accept)  r_lfsr <= w_st[N];
  end

  // Words accepted since the last seed load; wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_word_cnt <= 16'h0000;
    else if (seed_load) r_word_cnt <= 16'h0000;
    else if (w_accept)  r_word_cnt <= r_word_cnt + 16'd1;
  end

  // Output register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data ^ w_ks;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: single-word vector table plus
// sequences for backpressure, seed/accept collision, reset, wrap and chaining.
module tb_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] out_data, word_cnt;

  // chained pair
  logic        c_seed_load = 1'b0;
  logic [15:0] c_seed = '0;
  logic        c_in_valid = 1'b0;
  logic [15:0] c_in_data = '0;
  logic        c_b_ready = 1'b1;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_out_data, a_word_cnt, b_out_data, b_word_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xor_descrambler u_dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_cnt(word_cnt));

  xor_descrambler u_a (
    .clk(clk), .rst_n(rst_n), .seed_load(c_seed_load), .seed(c_seed),
    .in_valid(c_in_valid), .in_ready(a_in_ready), .in_data(c_in_data),
    .out_valid(a_out_valid), .out_ready(b_in_ready), .out_data(a_out_data),
    .word_cnt(a_word_cnt));

  xor_descrambler u_b (
    .clk(clk), .rst_n(rst_n), .seed_load(c_seed_load), .seed(c_seed),
    .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data),
    .out_valid(b_out_valid), .out_ready(c_b_ready), .out_data(b_out_data),
    .word_cnt(b_word_cnt));

  typedef struct {
    logic [15:0] sd;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: n serial steps of the Fibonacci register.
  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = {t[0] ^ t[2] ^ t[3] ^ t[5], t[15:1]};
    return t;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] words [3];
    int idx_in, idx_out;
    logic acc;

    tbl[0] = '{16'hACE1, 16'hAAAA, 16'h064B};
    tbl[1] = '{16'h0000, 16'h0000, 16'hACE1};
    tbl[2] = '{16'h1234, 16'hFFFF, 16'hEDCB};
    tbl[3] = '{16'h8001, 16'h0F0F, 16'h8F0E};
    tbl[4] = '{16'hFFFF, 16'h1234, 16'hEDCB};

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;

    // unseeded: nothing accepted
    in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b1;
    #1 chk("unseeded_in_ready", in_ready, 0);
    tick();
    chk("unseeded_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // single-word vector table
    for (int i = 0; i < 5; i++) begin
      load_seed(tbl[i].sd);
      chk("tbl_cnt0", word_cnt, 0);
      in_valid = 1'b1; in_data = tbl[i].din; out_ready = 1'b1;
      #1 chk("tbl_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_data", out_data, tbl[i].dout);
      chk("tbl_cnt1", word_cnt, 1);
      tick();
      chk("tbl_drain", out_valid, 0);
    end

    // backpressure: second word waits, first held stable
    load_seed(16'hACE1);
    in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b1;
    tick();
    in_data = 16'h0F0F; out_ready = 1'b0;
    #1 chk("bp_in_ready", in_ready, 0);
    tick();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 16'h064B);
    chk("bp_hold_cnt", word_cnt, 1);
    tick();
    chk("bp_hold_data2", out_data, 16'h064B);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    m = adv(16'hACE1, 16);
    chk("bp_word2", out_data, 16'h0F0F ^ m);
    chk("bp_cnt2", word_cnt, 2);
    tick();
    chk("bp_drain", out_valid, 0);

    // seed_load and in_valid collide: seed wins
    seed_load = 1'b1; seed = 16'h1234; in_valid = 1'b1; in_data = 16'h5555;
    #1 chk("coll_in_ready", in_ready, 0);
    tick();
    seed_load = 1'b0;
    chk("coll_no_accept", out_valid, 0);
    chk("coll_cnt", word_cnt, 0);
    tick();
    in_valid = 1'b0;
    chk("coll_next_data", out_data, 16'h4761);
    chk("coll_next_cnt", word_cnt, 1);

    // seed load leaves a pending word alone
    out_ready = 1'b0;
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("pend_valid", out_valid, 1);
    chk("pend_data", out_data, 16'h4761);
    chk("pend_cnt", word_cnt, 0);

    // async reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b1;
    #1 chk("post_rst_ready", in_ready, 0);
    tick();
    chk("post_rst_no_acc", out_valid, 0);
    in_valid = 1'b0;
    load_seed(16'hACE1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", out_data, 16'h064B);

    // word_cnt wrap with a full-rate stream
    load_seed(16'h0000);
    m = 16'hACE1;
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (i < 65534) m = adv(m, 16);
    end
    chk("wrap_cnt_ffff", word_cnt, 16'hFFFF);
    chk("wrap_data", out_data, m);
    tick();
    in_valid = 1'b0;
    m = adv(m, 16);
    chk("wrap_cnt_0", word_cnt, 0);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_data2", out_data, m);
    tick();

    // chained pair reproduces the original stream
    words[0] = 16'hAAAA; words[1] = 16'h0F0F; words[2] = 16'h00FF;
    c_seed_load = 1'b1; c_seed = 16'h1234;
    tick();
    c_seed_load = 1'b0;
    idx_in = 0; idx_out = 0;
    for (int cyc = 0; cyc < 20 && idx_out < 3; cyc++) begin
      c_in_valid = (idx_in < 3);
      c_in_data  = (idx_in < 3) ? words[idx_in] : 16'h0000;
      #1 acc = c_in_valid & a_in_ready;
      tick();
      if (acc) idx_in++;
      if (b_out_valid) begin
        if (idx_out < 3) chk("chain_word", b_out_data, words[idx_out]);
        idx_out++;
      end
    end
    c_in_valid = 1'b0;
    chk("chain_count", idx_out, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
